// File: rtl/apb4_plic_claimer.sv
// APB4 master that claims interrupt IDs from a PLIC claim/complete register and writes back
// completions offered by the core through a one-entry buffer.
module apb4_plic_claimer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] CC_OFFSET = 32'h24,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        irq_i,
  output logic [31:0] paddr,
  output logic [2:0]  pprot,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic        pslverr,
  output logic        claim_valid_o,
  output logic [4:0]  claim_id_o,
  input  logic        claim_ready_i,
  input  logic        done_valid_i,
  input  logic [4:0]  done_id_i,
  output logic        done_ready_o,
  output logic        err_o
);

  localparam logic [31:0] CcAddr   = BASE_ADDR + CC_OFFSET;
  localparam logic [7:0]  WaitLast = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StRSetup, StRAccess, StHold, StWSetup, StWAccess
  } state_e;

  state_e      state_q, state_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic        claim_valid_q, claim_valid_d;
  logic [4:0]  claim_id_q, claim_id_d;
  logic        err_q, err_d;
  logic        buf_full_q, buf_full_d;
  logic [4:0]  buf_id_q, buf_id_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  // Only the ID field of the claim register is meaningful.
  logic unused_prdata;
  assign unused_prdata = ^prdata[31:5];

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    claim_valid_d = claim_valid_q;
    claim_id_d    = claim_id_q;
    err_d         = 1'b0;
    buf_full_d    = buf_full_q;
    buf_id_d      = buf_id_q;
    wait_cnt_d    = wait_cnt_q;

    if (done_valid_i && !buf_full_q) begin
      buf_full_d = 1'b1;
      buf_id_d   = done_id_i;
    end

    unique case (state_q)
      StIdle: begin
        // A pending completion is written back before a new claim is attempted.
        if (buf_full_q) begin
          state_d  = StWSetup;
          psel_d   = 1'b1;
          paddr_d  = CcAddr;
          pwrite_d = 1'b1;
          pwdata_d = {27'b0, buf_id_q};
          pstrb_d  = 4'hF;
        end else if (irq_i) begin
          state_d  = StRSetup;
          psel_d   = 1'b1;
          paddr_d  = CcAddr;
          pwrite_d = 1'b0;
          pstrb_d  = 4'h0;
        end
      end
      StRSetup, StWSetup: begin
        state_d    = (state_q == StRSetup) ? StRAccess : StWAccess;
        penable_d  = 1'b1;
        wait_cnt_d = 8'd0;
      end
      StRAccess, StWAccess: begin
        if (pready || wait_cnt_q == WaitLast) begin
          state_d   = StIdle;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          err_d     = !pready || pslverr;
          if (state_q == StWAccess) begin
            buf_full_d = 1'b0;
          end else if (pready && !pslverr && prdata[4:0] != 5'd0) begin
            state_d       = StHold;
            claim_valid_d = 1'b1;
            claim_id_d    = prdata[4:0];
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (claim_ready_i) begin
          state_d       = StIdle;
          claim_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= StIdle;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= 32'd0;
      pwdata_q      <= 32'd0;
      pstrb_q       <= 4'h0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= 5'd0;
      err_q         <= 1'b0;
      buf_full_q    <= 1'b0;
      buf_id_q      <= 5'd0;
      wait_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
      err_q         <= err_d;
      buf_full_q    <= buf_full_d;
      buf_id_q      <= buf_id_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign paddr         = paddr_q;
  assign pprot         = 3'b000;
  assign psel          = psel_q;
  assign penable       = penable_q;
  assign pwrite        = pwrite_q;
  assign pwdata        = pwdata_q;
  assign pstrb         = pstrb_q;
  assign claim_valid_o = claim_valid_q;
  assign claim_id_o    = claim_id_q;
  assign done_ready_o  = !buf_full_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_apb4_plic_claimer.sv
// Bench for apb4_plic_claimer: an APB slave model queues the expected claims, errors and
// write-backs, and independent monitors pop and compare them as the DUT presents them.
module tb_apb4_plic_claimer;

  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] CcAddr = 32'h24;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        irq_i;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic [31:0] prdata = 32'd0;
  logic        pslverr = 1'b0;
  logic        claim_valid_o;
  logic [4:0]  claim_id_o;
  logic        claim_ready_i;
  logic        done_valid_i;
  logic [4:0]  done_id_i;
  logic        done_ready_o;
  logic        err_o;

  apb4_plic_claimer #(
    .BASE_ADDR(32'h0000_0000),
    .CC_OFFSET(32'h24),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .pclk         (pclk),
    .presetn      (presetn),
    .irq_i        (irq_i),
    .paddr        (paddr),
    .pprot        (pprot),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .pwdata       (pwdata),
    .pstrb        (pstrb),
    .pready       (pready),
    .prdata       (prdata),
    .pslverr      (pslverr),
    .claim_valid_o(claim_valid_o),
    .claim_id_o   (claim_id_o),
    .claim_ready_i(claim_ready_i),
    .done_valid_i (done_valid_i),
    .done_id_i    (done_id_i),
    .done_ready_o (done_ready_o),
    .err_o        (err_o)
  );

  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_err = 0;

  logic [4:0] claim_q[$];
  logic [4:0] wr_q[$];
  logic       err_q[$];

  // Slave knobs: fixed responses for directed tests, random otherwise.
  logic        fx = 1'b1;
  int          fx_waits = 0;
  logic [31:0] fx_data = 32'd7;
  logic        fx_err = 1'b0;
  logic        fx_to = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic offer_done(input logic [4:0] id);
    done_valid_i = 1'b1;
    done_id_i    = id;
    if (done_ready_o) wr_q.push_back(id);
  endtask

  // APB slave model and protocol checker; drives responses for the coming edge.
  logic        s_act = 1'b0, s_wr, s_err, s_to, s_prev_psel = 1'b0;
  logic [31:0] s_addr, s_wd, s_data;
  logic [3:0]  s_st;
  int          s_n, s_waits;
  always begin
    @(negedge pclk);
    if (!presetn) begin
      s_act = 1'b0; pready = 1'b0; pslverr = 1'b0; s_prev_psel = 1'b0;
    end else begin
      if (psel && !penable) begin
        chk("idle_gap", s_prev_psel, 1'b0);
        chk("paddr", paddr, CcAddr);
        chk("pprot", pprot, 3'b000);
        chk("pstrb", pstrb, pwrite ? 4'hF : 4'h0);
        if (pwrite) begin
          if (wr_q.size() == 0) chk("write_spurious", pwrite, 1'b0);
          else chk("pwdata", pwdata, {27'b0, wr_q.pop_front()});
        end
        s_addr = paddr; s_wr = pwrite; s_wd = pwdata; s_st = pstrb; s_n = 0; s_act = 1'b1;
        if (fx) begin
          s_waits = fx_waits; s_data = fx_data; s_err = fx_err; s_to = fx_to;
        end else begin
          int r;
          r = $urandom_range(0, 99);
          s_to  = (r < 6);
          s_err = (r >= 6 && r < 14);
          s_waits = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3);
          s_data = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFE0) : $urandom;
        end
        if (s_to) err_q.push_back(1'b1);
        pready = 1'b0; pslverr = 1'b0;
      end else if (psel && penable) begin
        if (!s_act) chk("access_after_done", penable, 1'b0);
        s_n++;
        chk("access_addr", paddr, s_addr);
        chk("access_ctrl", {pwrite, pstrb, pwdata}, {s_wr, s_st, s_wd});
        chk("wait_bound", (s_n <= int'(TIMEOUT)), 1'b1);
        if (s_act && !s_to && s_n > s_waits) begin
          pready = 1'b1; prdata = s_data; pslverr = s_err; s_act = 1'b0;
          if (s_err) err_q.push_back(1'b1);
          else if (!s_wr && s_data[4:0] != 5'd0) claim_q.push_back(s_data[4:0]);
        end else begin
          pready = 1'b0; pslverr = 1'b0;
        end
      end else begin
        if (s_act) begin
          if (s_to) chk("timeout_cycles", s_n, TIMEOUT);
          else chk("transfer_aborted", psel, 1'b1);
          s_act = 1'b0;
        end
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
      end
      s_prev_psel = psel;
    end
  end

  // Claim monitor.
  logic       c_prev_v = 1'b0, c_prev_acc = 1'b0;
  logic [4:0] c_prev_id;
  always begin
    @(negedge pclk);
    #1;
    if (!presetn) begin
      c_prev_v = 1'b0; c_prev_acc = 1'b0;
    end else begin
      if (claim_valid_o) begin
        if (!c_prev_v || c_prev_acc) begin
          if (claim_q.size() == 0) chk("claim_spurious", claim_valid_o, 1'b0);
          else chk("claim_id", claim_id_o, claim_q.pop_front());
        end else begin
          chk("claim_hold", claim_id_o, c_prev_id);
        end
      end
      c_prev_v = claim_valid_o; c_prev_id = claim_id_o;
      c_prev_acc = claim_valid_o && claim_ready_i;
    end
  end

  // Error monitor.
  always begin
    @(negedge pclk);
    #1;
    if (presetn && err_o) begin
      if (err_q.size() == 0) chk("err_spurious", err_o, 1'b0);
      else chk("err_pulse", err_o, err_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic sel_log[12], en_log[12], wr_log[12];
  initial begin
    int first, second, nw, ne, bad;
    presetn = 1'b1; irq_i = 1'b0; claim_ready_i = 1'b0; done_valid_i = 1'b0; done_id_i = 5'd0;
    #2 presetn = 1'b0;
    #1;
    chk("rst_bus_ctrl", {psel, penable, pwrite, pstrb}, 7'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_claim", {claim_valid_o, claim_id_o}, 6'd0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_done_ready", done_ready_o, 1'b1);
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);

    // Basic claim latency with a zero-wait slave.
    claim_ready_i = 1'b1; irq_i = 1'b1;
    @(negedge pclk); irq_i = 1'b0;
    chk("lat_k1_sel", {psel, penable}, 2'b10);
    chk("lat_k1_addr", paddr, 32'h24);
    chk("lat_k1_write", pwrite, 1'b0);
    @(negedge pclk);
    chk("lat_k2_enable", {psel, penable}, 2'b11);
    @(negedge pclk);
    chk("lat_k3_claim", {claim_valid_o, claim_id_o}, {1'b1, 5'd7});
    @(negedge pclk);
    chk("lat_claim_drop", claim_valid_o, 1'b0);
    repeat (2) @(negedge pclk);

    // Pending completion beats a new claim.
    fx_data = 32'd3; claim_ready_i = 1'b0; irq_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      if (claim_valid_o) break;
    end
    chk("prio_hold", claim_valid_o, 1'b1);
    offer_done(5'd9);
    @(negedge pclk); done_valid_i = 1'b0; claim_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge pclk);
      sel_log[i] = psel; en_log[i] = penable; wr_log[i] = pwrite;
    end
    irq_i = 1'b0;
    first = -1; second = -1;
    for (int i = 0; i < 12; i++) begin
      if (sel_log[i] && !en_log[i]) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk("prio_found", (first >= 0 && second > 0), 1'b1);
    if (first >= 0 && second > 0) begin
      chk("prio_write_first", wr_log[first], 1'b1);
      chk("prio_read_second", wr_log[second], 1'b0);
      chk("prio_idle_gap", sel_log[second-1], 1'b0);
    end
    repeat (10) @(negedge pclk);

    // Write-back with two wait states.
    fx_waits = 2;
    offer_done(5'd7);
    @(negedge pclk); done_valid_i = 1'b0;
    nw = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      if (psel && pwrite) begin
        nw++;
        if (done_ready_o) bad++;
      end
    end
    chk("wr_cycles", nw, 4);
    chk("wr_done_ready_low", bad, 0);
    chk("wr_done_ready_back", done_ready_o, 1'b1);

    // Timeout, then slave error on a read.
    fx_waits = 0; fx_data = 32'd7;
    for (int t = 0; t < 2; t++) begin
      fx_to = (t == 0); fx_err = (t == 1);
      @(negedge pclk); irq_i = 1'b1;
      @(negedge pclk); irq_i = 1'b0;
      ne = 0;
      repeat (25) begin
        @(negedge pclk);
        if (err_o) ne++;
      end
      chk(t == 0 ? "timeout_err_once" : "slverr_err_once", ne, 1);
    end
    fx_to = 1'b0; fx_err = 1'b0;

    // Reset in the middle of a read, with a completion buffered.
    fx_waits = 10;
    @(negedge pclk); irq_i = 1'b1;
    @(negedge pclk); irq_i = 1'b0;
    @(negedge pclk);
    chk("rst_mid_in_access", {psel, penable}, 2'b11);
    done_valid_i = 1'b1; done_id_i = 5'd4;
    @(negedge pclk); done_valid_i = 1'b0;
    chk("rst_mid_buf_full", done_ready_o, 1'b0);
    #2 presetn = 1'b0;
    #1;
    chk("rst_mid_bus", {psel, penable, pwrite, pstrb}, 7'd0);
    chk("rst_mid_addr_data", {paddr, pwdata}, 64'd0);
    chk("rst_mid_claim_err", {claim_valid_o, claim_id_o, err_o}, 7'd0);
    chk("rst_mid_done_ready", done_ready_o, 1'b1);
    claim_q.delete(); err_q.delete(); wr_q.delete();
    @(negedge pclk);
    @(negedge pclk); presetn = 1'b1;
    repeat (3) @(negedge pclk);

    // Randomized traffic.
    fx = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge pclk);
      irq_i = ($urandom_range(0, 3) != 0);
      claim_ready_i = $urandom_range(0, 1) == 1;
      done_valid_i = 1'b0;
      if ($urandom_range(0, 2) == 0) offer_done(5'($urandom));
    end

    @(negedge pclk);
    irq_i = 1'b0; done_valid_i = 1'b0; claim_ready_i = 1'b1;
    repeat (60) @(negedge pclk);
    chk("drain_claims", claim_q.size(), 0);
    chk("drain_writes", wr_q.size(), 0);
    chk("drain_errs", err_q.size(), 0);
    chk("drain_idle", {psel, claim_valid_o, done_ready_o}, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb4_plic_claimer.md
APB4_PLIC_CLAIMER -- requirements
Module: apb4_plic_claimer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the PLIC APB4 base address.
REQ-002 SHALL have parameter CC_OFFSET, default 32'h24, the claim/complete register byte offset (word index 9).
REQ-003 SHALL have parameter TIMEOUT, default 16, the maximum access-phase wait cycles with pready low; legal range 1..255.
REQ-004 The block has one clock, pclk, and one reset, presetn, which is asynchronous and active-low.
- pclk  in  1  clock.
- presetn  in  1  async active-low reset.
- irq_i  in  1  PLIC target interrupt request, level.
- paddr  out  32  APB4 address.
- pprot  out  3  tied 3'b000.
- psel  out  1  APB4 select.
- penable  out  1  APB4 enable.
- pwrite  out  1  APB4 direction.
- pwdata  out  32  write data.
- pstrb  out  4  4'hF on writes, 4'h0 on reads.
- pready  in  1  slave ready.
- prdata  in  32  read data.
- pslverr  in  1  slave error.
- claim_valid_o  out  1  claimed ID available.
- claim_id_o  out  5  claimed ID.
- claim_ready_i  in  1  core accepts claim.
- done_valid_i  in  1  core offers completion ID.
- done_id_i  in  5  completion ID.
- done_ready_o  out  1  completion buffer empty.
- err_o  out  1  one-cycle pulse on pslverr or timeout.

Function
REQ-005 SHALL implement states IDLE, RSETUP, RACCESS, HOLD, WSETUP and WACCESS; all APB and core-side outputs SHALL be registered.
REQ-006 SHALL hold a one-entry completion buffer, loaded on done_valid_i && done_ready_o; done_ready_o = buffer empty.
REQ-007 In IDLE, when the buffer is full -> WSETUP. Otherwise, when irq_i=1 -> RSETUP. A pending completion wins over a new claim.
REQ-008 In RSETUP/WSETUP: psel=1, penable=0, paddr=BASE_ADDR+CC_OFFSET; pwrite=0 for reads, 1 for writes; for writes, pwdata={27'b0, buffered ID}. Exactly one cycle, then the matching ACCESS state.
REQ-009 In ACCESS: psel=1, penable=1, and paddr/pwrite/pwdata/pstrb stay stable until the edge where pready=1.
REQ-010 At the RACCESS edge with pready=1 and pslverr=0:
- prdata[4:0]!=0 -> HOLD, claim_valid_o=1, claim_id_o=prdata[4:0].
- prdata[4:0]==0 -> IDLE, no claim.
- prdata[31:5] ignored.
REQ-011 HOLD keeps claim_valid_o and claim_id_o stable until claim_ready_i=1; at that edge claim_valid_o -> 0 and state -> IDLE.
REQ-012 At the WACCESS edge with pready=1: buffer cleared, state -> IDLE; done_ready_o=1 the following cycle.
REQ-013 psel and penable SHALL be 0 in IDLE and HOLD, giving at least one idle bus cycle between transfers.
REQ-014 Latency: irq_i sampled high in IDLE at edge k gives psel=1 in cycle k+1 and penable=1 in cycle k+2. With zero-wait pready, claim_valid_o=1 in cycle k+3.
REQ-015 pslverr=1 with pready=1 in ACCESS SHALL pulse err_o and go to IDLE. On a read, no claim is issued. On a write, the buffer is cleared (entry dropped).
REQ-016 A wait counter SHALL:
- clear on entry to ACCESS;
- increment each ACCESS cycle with pready=0;
- on reaching TIMEOUT: deassert psel/penable next cycle, pulse err_o, go to IDLE, with the same read/write consequences as REQ-015.
REQ-017 done_valid_i may be accepted in any state when the buffer is empty, including during HOLD and RACCESS.
REQ-018 irq_i changes outside IDLE SHALL be ignored; irq_i is re-sampled on return to IDLE.

Reset
REQ-019 presetn=0 SHALL asynchronously force:
- state IDLE;
- psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0;
- claim_valid_o=0, claim_id_o=0, err_o=0;
- buffer empty, so done_ready_o=1;
- wait counter 0.
REQ-020 Reset asserted mid-transfer SHALL abort the transfer without an err_o pulse; any buffered completion is lost.

Verification
REQ-021 irq_i=1, zero-wait slave returns prdata=32'h0000_0007, claim_ready_i=1 -> paddr=32'h24, pwrite=0, claim_valid_o=1 with claim_id_o=7 at cycle k+3, then IDLE.
REQ-022 done_valid_i=1 with done_id_i=7, slave adds 2 wait states -> pwrite=1, pwdata=32'h7, pstrb=4'hF for 4 bus cycles; done_ready_o=0 until completion.
REQ-023 irq_i=1 and done buffer full in the same IDLE cycle -> write issued first, read issued after at least one idle bus cycle.
REQ-024 Read returns prdata=0 -> no claim_valid_o and no err_o; a new read starts if irq_i is still 1.
REQ-025 pready held 0 for 16 cycles -> err_o pulses once, psel drops, state IDLE; a pslverr=1 read -> err_o pulse and no claim.
REQ-026 presetn asserted during RACCESS -> all outputs take reset values immediately; done_ready_o=1.
